// File: rtl/mmu_pkg.sv
// Shared definitions for the mapper context loader: sequencer states,
// mapper register offsets and the register-address helper.
package mmu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WR_AKEY,
        RD,
        WR_MAP,
        WR_OKEY,
        FIN,
        ABORT
    } mmu_state_t;

    localparam logic [6:0] MMU_OFS_KVMMU = 7'h40;
    localparam logic [6:0] MMU_OFS_SU    = 7'h48;
    localparam logic [6:0] MMU_OFS_FUSE  = 7'h49;
    localparam logic [6:0] MMU_OFS_AKEY  = 7'h4A;
    localparam logic [6:0] MMU_OFS_OKEY  = 7'h4B;

    localparam int MMU_MAP_BYTES = 64;

    function automatic logic [15:0] mmu_reg_adr(input logic [15:0] base, input logic [6:0] ofs);
        return base + {9'd0, ofs};
    endfunction

endpackage

// File: rtl/mmu_rd_timeout.sv
// Loadable down-counter guarding one outstanding memory read; the zero flag
// marks the last cycle an acknowledge may still arrive.
module mmu_rd_timeout #(
    parameter logic [7:0] LOAD_VALUE = 8'd254
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    logic [7:0] count_r;

    // Reload on read entry, count down only while enabled, saturate at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= LOAD_VALUE;
        end else if (en && (count_r != 8'd0)) begin
            count_r <= count_r - 8'd1;
        end
    end

    assign zero = (count_r == 8'd0);

endmodule

// File: rtl/mmu_context_loader.sv
// Bus-master sequencer that loads one task's map context into the mapper:
// access key, 64 map bytes copied from memory, then the operate key.
module mmu_context_loader
    import mmu_pkg::*;
#(
    parameter logic [15:0] pIOAddress = 16'hF800,
    parameter logic [6:0]  pMapBytes  = 7'd64,
    parameter logic [7:0]  pTimeout   = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  task_key,
    input  logic [23:0] src_base,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        mem_req,
    output logic [23:0] mem_adr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dat,
    output logic [15:0] io_adr,
    output logic [7:0]  io_dat,
    output logic        io_we
);

    mmu_state_t  state_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        bus_req_r;
    logic        mem_req_r;
    logic        io_we_r;
    logic [23:0] mem_adr_r;
    logic [15:0] io_adr_r;
    logic [7:0]  io_dat_r;
    logic [6:0]  cnt_r;
    logic [7:0]  key_r;
    logic [23:0] src_r;

    logic tmo_load_s;
    logic tmo_en_s;
    logic tmo_zero_s;

    // Loaded one short so the abort lands exactly pTimeout cycles after mem_req rises.
    mmu_rd_timeout #(
        .LOAD_VALUE(pTimeout - 8'd1)
    ) u_rd_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (tmo_load_s),
        .en     (tmo_en_s),
        .zero   (tmo_zero_s)
    );

    assign tmo_load_s = bus_gnt && ((state_r == WR_AKEY) || (state_r == WR_MAP));
    assign tmo_en_s   = bus_gnt && (state_r == RD) && !mem_ack;

    // Sequencer: every state waits on bus_gnt, so a dropped grant freezes it in place.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            bus_req_r <= 1'b0;
            mem_req_r <= 1'b0;
            io_we_r   <= 1'b0;
            mem_adr_r <= 24'd0;
            io_adr_r  <= pIOAddress;
            io_dat_r  <= 8'd0;
            cnt_r     <= 7'd0;
            key_r     <= 8'd0;
            src_r     <= 24'd0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        key_r     <= task_key;
                        src_r     <= src_base & 24'hFFFFFE;
                        busy_r    <= 1'b1;
                        bus_req_r <= 1'b1;
                        state_r   <= REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        io_adr_r <= mmu_reg_adr(pIOAddress, MMU_OFS_AKEY);
                        io_dat_r <= key_r;
                        io_we_r  <= 1'b1;
                        state_r  <= WR_AKEY;
                    end
                end
                WR_AKEY: begin
                    if (bus_gnt) begin
                        io_we_r   <= 1'b0;
                        cnt_r     <= 7'd0;
                        mem_req_r <= 1'b1;
                        mem_adr_r <= src_r;
                        state_r   <= RD;
                    end
                end
                RD: begin
                    if (bus_gnt) begin
                        if (mem_ack) begin
                            mem_req_r <= 1'b0;
                            io_adr_r  <= mmu_reg_adr(pIOAddress, {1'b0, cnt_r[5:0]});
                            io_dat_r  <= mem_dat;
                            io_we_r   <= 1'b1;
                            state_r   <= WR_MAP;
                        end else if (tmo_zero_s) begin
                            mem_req_r <= 1'b0;
                            busy_r    <= 1'b0;
                            bus_req_r <= 1'b0;
                            err_r     <= 1'b1;
                            state_r   <= ABORT;
                        end
                    end
                end
                WR_MAP: begin
                    if (bus_gnt) begin
                        if (cnt_r == (pMapBytes - 7'd1)) begin
                            io_adr_r <= mmu_reg_adr(pIOAddress, MMU_OFS_OKEY);
                            io_dat_r <= key_r;
                            state_r  <= WR_OKEY;
                        end else begin
                            io_we_r   <= 1'b0;
                            cnt_r     <= cnt_r + 7'd1;
                            mem_req_r <= 1'b1;
                            mem_adr_r <= src_r + {17'd0, cnt_r + 7'd1};
                            state_r   <= RD;
                        end
                    end
                end
                WR_OKEY: begin
                    if (bus_gnt) begin
                        io_we_r   <= 1'b0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        bus_req_r <= 1'b0;
                        state_r   <= FIN;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                ABORT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign bus_req = bus_req_r;
    assign mem_req = mem_req_r;
    assign mem_adr = mem_adr_r;
    assign io_adr  = io_adr_r;
    assign io_dat  = io_dat_r;
    // A write strobe held across a grant drop stays masked until grant returns.
    assign io_we   = io_we_r & bus_gnt;

endmodule

// File: tb/tb_mmu_context_loader.sv
// Directed bench for mmu_context_loader: scoreboarded mapper writes against a
// zero-wait memory model with a per-address ack delay.
module tb_mmu_context_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  task_key;
    logic [23:0] src_base;
    logic        busy, done, err, bus_req, bus_gnt;
    logic        mem_req, mem_ack;
    logic [23:0] mem_adr;
    logic [7:0]  mem_dat;
    logic [15:0] io_adr;
    logic [7:0]  io_dat;
    logic        io_we;

    typedef struct packed {
        logic [15:0] adr;
        logic [7:0]  dat;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_wr;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic        saw_zero_rd = 1'b0;
    logic [8:0]  req_age = 9'd0;
    logic [23:0] hold_adr;
    logic [8:0]  hold_delay;

    mmu_context_loader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .task_key(task_key),
        .src_base(src_base),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bus_req (bus_req),
        .bus_gnt (bus_gnt),
        .mem_req (mem_req),
        .mem_adr (mem_adr),
        .mem_ack (mem_ack),
        .mem_dat (mem_dat),
        .io_adr  (io_adr),
        .io_dat  (io_dat),
        .io_we   (io_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    // Memory model: acks at once, except hold_adr which acks after hold_delay cycles.
    always @(posedge clk) req_age <= (mem_req && !mem_ack) ? req_age + 9'd1 : 9'd0;

    always_comb begin
        mem_ack = mem_req && ((mem_adr != hold_adr) || (req_age == hold_delay));
        mem_dat = mem_byte(mem_adr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every mapper write, plus pulse counters.
    always @(negedge clk) begin
        if (io_we) begin
            wr_cnt <= wr_cnt + 1;
            check("write_with_grant", 32'(bus_gnt), 32'd1);
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed=%h<-%h expected=none", io_adr, io_dat);
            end
            if (exp_q.size() > 0) begin
                exp_wr = exp_q.pop_front();
                check("io_adr", 32'(io_adr), 32'(exp_wr.adr));
                check("io_dat", 32'(io_dat), 32'(exp_wr.dat));
            end
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (mem_ack && (mem_adr == 24'h000000)) saw_zero_rd <= 1'b1;
    end

    task automatic push_load(input logic [7:0] key, input logic [23:0] src, input int nbytes,
                             input logic with_okey);
        logic [23:0] a;
        exp_q.push_back('{adr: 16'hF84A, dat: key});
        for (int i = 0; i < nbytes; i++) begin
            a = src + 24'(i);
            exp_q.push_back('{adr: 16'hF800 + 16'(i), dat: mem_byte(a)});
        end
        if (with_okey) exp_q.push_back('{adr: 16'hF84B, dat: key});
    endtask

    task automatic pulse_start(input logic [7:0] key, input logic [23:0] src, output int scyc);
        @(negedge clk);
        task_key = key;
        src_base = src;
        start    = 1'b1;
        scyc     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int ecyc, output logic got_done);
        ecyc     = 0;
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) begin
                ecyc     = cyc;
                got_done = done;
                return;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_io_we"},   32'(io_we),   32'd0);
        check({tag, "_io_adr"},  32'(io_adr),  32'hF800);
        check({tag, "_io_dat"},  32'(io_dat),  32'd0);
        check({tag, "_mem_adr"}, 32'(mem_adr), 32'd0);
    endtask

    initial begin
        int   s, e, rq, base_wr, base_done, base_err, pre;
        logic gd;

        reset_n    = 1'b0;
        start      = 1'b0;
        bus_gnt    = 1'b1;
        task_key   = 8'd0;
        src_base   = 24'd0;
        hold_adr   = 24'h800000;
        hold_delay = 9'h1FF;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Basic load
        push_load(8'h05, 24'h001000, 64, 1'b1);
        base_wr = wr_cnt;
        pulse_start(8'h05, 24'h001000, s);
        wait_end(400, e, gd);
        check("basic_done_cycle", 32'(e - s), 32'd132);
        check("basic_is_done", 32'(gd), 32'd1);
        @(negedge clk);
        check("basic_done_one_cycle", 32'(done), 32'd0);
        check("basic_busy_clear", 32'(busy), 32'd0);
        check("basic_write_count", 32'(wr_cnt - base_wr), 32'd66);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

        // Grant drop for 10 cycles after the 20th map write
        push_load(8'h1F, 24'h002000, 64, 1'b1);
        base_wr = wr_cnt;
        pulse_start(8'h1F, 24'h002000, s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (io_we && (io_adr == 16'hF813)) break;
        end
        @(posedge clk);
        #1 bus_gnt = 1'b0;
        pre = wr_cnt - base_wr;
        check("gnt_writes_before", 32'(pre), 32'd21);
        repeat (5) @(negedge clk);
        check("gnt_mem_req_held", 32'(mem_req), 32'd1);
        check("gnt_busy_held", 32'(busy), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("gnt_no_write_while_low", 32'(wr_cnt - base_wr), 32'(pre));
        bus_gnt = 1'b1;
        wait_end(400, e, gd);
        check("gnt_done_cycle", 32'(e - s), 32'd142);
        @(negedge clk);
        check("gnt_write_count", 32'(wr_cnt - base_wr), 32'd66);
        check("gnt_queue_empty", 32'(exp_q.size()), 32'd0);

        // Timeout on byte 7
        hold_adr   = 24'h003007;
        hold_delay = 9'h1FF;
        push_load(8'h22, 24'h003000, 7, 1'b0);
        base_wr   = wr_cnt;
        base_done = done_cnt;
        pulse_start(8'h22, 24'h003000, s);
        rq = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && (mem_adr == hold_adr)) begin
                rq = cyc;
                break;
            end
        end
        wait_end(400, e, gd);
        check("tmo_err_latency", 32'(e - rq), 32'd255);
        check("tmo_is_err", 32'(gd), 32'd0);
        @(negedge clk);
        check("tmo_bus_req_clear", 32'(bus_req), 32'd0);
        check("tmo_busy_clear", 32'(busy), 32'd0);
        check("tmo_err_one_cycle", 32'(err), 32'd0);
        check("tmo_write_count", 32'(wr_cnt - base_wr), 32'd8);
        check("tmo_no_okey", 32'(exp_q.size()), 32'd0);
        check("tmo_no_done", 32'(done_cnt - base_done), 32'd0);

        // Ack arriving on the cycle the counter reaches zero
        hold_adr   = 24'h004005;
        hold_delay = 9'd254;
        push_load(8'h3C, 24'h004000, 64, 1'b1);
        base_err = err_cnt;
        pulse_start(8'h3C, 24'h004000, s);
        wait_end(700, e, gd);
        check("tie_is_done", 32'(gd), 32'd1);
        check("tie_done_cycle", 32'(e - s), 32'd386);
        @(negedge clk);
        check("tie_no_err", 32'(err_cnt - base_err), 32'd0);
        check("tie_queue_empty", 32'(exp_q.size()), 32'd0);
        hold_adr = 24'h800000;

        // Start while busy, with a source that wraps past 2^24
        push_load(8'hE3, 24'hFFFFF0, 64, 1'b1);
        base_wr   = wr_cnt;
        base_done = done_cnt;
        pulse_start(8'hE3, 24'hFFFFF0, s);
        repeat (49) @(negedge clk);
        task_key = 8'h99;
        src_base = 24'h123456;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(400, e, gd);
        check("wrap_done_cycle", 32'(e - s), 32'd132);
        repeat (5) @(negedge clk);
        check("wrap_single_done", 32'(done_cnt - base_done), 32'd1);
        check("wrap_not_restarted", 32'(busy), 32'd0);
        check("wrap_write_count", 32'(wr_cnt - base_wr), 32'd66);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
        check("wrap_read_zero", 32'(saw_zero_rd), 32'd1);

        // Reset after the 30th write
        push_load(8'h44, 24'h005000, 29, 1'b0);
        base_wr   = wr_cnt;
        base_done = done_cnt;
        base_err  = err_cnt;
        pulse_start(8'h44, 24'h005000, s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (io_we && (io_adr == 16'hF81C)) break;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_write_count", 32'(wr_cnt - base_wr), 32'd30);
        check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
        check("midrst_no_err", 32'(err_cnt - base_err), 32'd0);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        push_load(8'h07, 24'h006000, 64, 1'b1);
        pulse_start(8'h07, 24'h006000, s);
        wait_end(400, e, gd);
        check("post_rst_done_cycle", 32'(e - s), 32'd132);
        @(negedge clk);
        check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
